// File: rtl/phy_rx_sync_ctrl_if.sv
// Receive-side bundle for the PHY comma-sync controller: serial input plus
// the recovered byte, its classification pulses and the lock status.
interface phy_rx_sync_ctrl_if;
    logic       serial_in;
    logic       active;
    logic [7:0] data_out;
    logic       valid;
    logic       com_det;
    logic       idle_det;
    logic [1:0] state;

    modport master (
        output serial_in,
        input  active, data_out, valid, com_det, idle_det, state
    );

    modport slave (
        input  serial_in,
        output active, data_out, valid, com_det, idle_det, state
    );
endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// Comma-based byte alignment and link lock for a bit-serial PHY receiver:
// hunts for 8'hBC, confirms COM_LOCK aligned commas, drops lock after COM_TIMEOUT gaps.
module phy_rx_sync_ctrl #(
    parameter int unsigned COM_LOCK    = 4,
    parameter int unsigned COM_TIMEOUT = 16
) (
    input  logic               clk_32f,
    input  logic               rst,
    phy_rx_sync_ctrl_if.slave  rx
);

    localparam logic [7:0] LP_COM     = 8'hBC;
    localparam logic [7:0] LP_IDLE    = 8'h7C;
    localparam logic [3:0] LP_LOCK    = 4'(COM_LOCK);
    localparam logic [7:0] LP_TIMEOUT = 8'(COM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    // Only seven bits of history are needed: the oldest bit falls out of sr_next.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;
    logic [7:0] r_gap_cnt;
    logic [7:0] r_data;
    logic       r_active;
    logic       r_valid;
    logic       r_com_det;
    logic       r_idle_det;

    logic [7:0] w_sr_next;
    logic [2:0] w_bit_nxt;
    logic [3:0] w_com_nxt;
    logic [7:0] w_gap_nxt;
    logic [7:0] w_data_nxt;
    logic       w_valid_nxt;
    logic       w_com_det_nxt;
    logic       w_idle_det_nxt;
    logic       w_boundary;
    logic       w_is_com;
    logic       w_is_idle;
    logic [3:0] w_com_inc;
    logic [7:0] w_gap_inc;

    assign w_sr_next  = {r_sr, rx.serial_in};
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_is_com   = (w_sr_next == LP_COM);
    assign w_is_idle  = (w_sr_next == LP_IDLE);
    assign w_com_inc  = (r_com_cnt == '1) ? r_com_cnt : r_com_cnt + 4'd1;
    assign w_gap_inc  = (r_gap_cnt == '1) ? r_gap_cnt : r_gap_cnt + 8'd1;

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            r_state    <= ST_UNSYNC;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_com_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_data     <= '0;
            r_active   <= 1'b0;
            r_valid    <= 1'b0;
            r_com_det  <= 1'b0;
            r_idle_det <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_next[6:0];
            r_bit_cnt  <= w_bit_nxt;
            r_com_cnt  <= w_com_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_data     <= w_data_nxt;
            r_active   <= (w_state_nxt == ST_SYNC);
            r_valid    <= w_valid_nxt;
            r_com_det  <= w_com_det_nxt;
            r_idle_det <= w_idle_det_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_nxt      = r_bit_cnt + 3'd1;
        w_com_nxt      = r_com_cnt;
        w_gap_nxt      = r_gap_cnt;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_com_det_nxt  = 1'b0;
        w_idle_det_nxt = 1'b0;

        unique case (r_state)
            ST_UNSYNC: begin
                w_bit_nxt = '0;
                w_com_nxt = '0;
                w_gap_nxt = '0;
                if (w_is_com) begin
                    w_state_nxt = ST_ALIGN;
                    w_com_nxt   = 4'd1;
                end
            end

            ST_ALIGN: begin
                if (w_boundary) begin
                    w_data_nxt = w_sr_next;
                    if (w_is_com) begin
                        w_com_nxt     = w_com_inc;
                        w_com_det_nxt = 1'b1;
                        if (w_com_inc == LP_LOCK) begin
                            w_state_nxt = ST_SYNC;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = ST_UNSYNC;
                        w_com_nxt   = '0;
                    end
                end
            end

            ST_SYNC: begin
                if (w_boundary) begin
                    w_data_nxt = w_sr_next;
                    if (w_is_com) begin
                        w_gap_nxt     = '0;
                        w_com_det_nxt = 1'b1;
                    end else begin
                        w_gap_nxt = w_gap_inc;
                        // The byte that exhausts the gap budget is dropped silently.
                        if (w_gap_inc == LP_TIMEOUT) begin
                            w_state_nxt = ST_UNSYNC;
                        end else if (w_is_idle) begin
                            w_idle_det_nxt = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_UNSYNC;
                w_bit_nxt   = '0;
                w_com_nxt   = '0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    assign rx.state    = r_state;
    assign rx.active   = r_active;
    assign rx.data_out = r_data;
    assign rx.valid    = r_valid;
    assign rx.com_det  = r_com_det;
    assign rx.idle_det = r_idle_det;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Bench for phy_rx_sync_ctrl: directed lock/timeout/reset scenarios and a
// randomized byte stream, all compared cycle by cycle against a bit-level model.
module tb_phy_rx_sync_ctrl;

    localparam int unsigned LOCK = 4;
    localparam int unsigned TMO  = 16;

    logic clk_32f = 1'b0;
    logic rst     = 1'b1;

    phy_rx_sync_ctrl_if rx ();

    phy_rx_sync_ctrl #(.COM_LOCK(LOCK), .COM_TIMEOUT(TMO)) dut (
        .clk_32f (clk_32f),
        .rst     (rst),
        .rx      (rx)
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 hunting, 1 confirming commas, 2 locked.
    int         m_sh, m_mode, m_since, m_ncom, m_ngap;
    logic [7:0] m_dout;
    bit         m_valid, m_com, m_idle;

    int         obs_valid, obs_com, obs_idle;
    logic [7:0] obs_valid_data, obs_idle_data;
    bit         q_bits[$];

    task automatic model_reset();
        m_sh = 0; m_mode = 0; m_since = 0; m_ncom = 0; m_ngap = 0;
        m_dout = 8'h00; m_valid = 0; m_com = 0; m_idle = 0;
    endtask

    task automatic model_bit(input bit b);
        m_sh = ((m_sh << 1) | int'(b)) & 255;
        m_valid = 0; m_com = 0; m_idle = 0;
        if (m_mode == 0) begin
            if (m_sh == 'hBC) begin
                m_mode = 1; m_since = 0; m_ncom = 1;
            end
        end else begin
            m_since++;
            if (m_since == 8) begin
                m_since = 0;
                m_dout  = 8'(m_sh);
                if (m_mode == 1) begin
                    if (m_sh == 'hBC) begin
                        m_ncom++;
                        m_com = 1;
                        if (m_ncom == int'(LOCK)) begin
                            m_mode = 2; m_ngap = 0;
                        end
                    end else begin
                        m_mode = 0; m_ncom = 0;
                    end
                end else begin
                    if (m_sh == 'hBC) begin
                        m_ngap = 0; m_com = 1;
                    end else begin
                        m_ngap++;
                        if (m_ngap == int'(TMO)) m_mode = 0;
                        else if (m_sh == 'h7C) m_idle = 1;
                        else m_valid = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_vec();
        return {2'(m_mode), (m_mode == 2), m_valid, m_com, m_idle, m_dout};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {rx.state, rx.active, rx.valid, rx.com_det, rx.idle_det, rx.data_out};
    endfunction

    task automatic clr_obs();
        obs_valid = 0; obs_com = 0; obs_idle = 0;
        obs_valid_data = 8'h00; obs_idle_data = 8'h00;
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) q_bits.push_back(v[i]);
    endtask

    task automatic drive_bit(input bit b);
        rx.serial_in = b;
        model_bit(b);
        @(posedge clk_32f);
        #1;
        obs_valid += int'(rx.valid);
        obs_com   += int'(rx.com_det);
        obs_idle  += int'(rx.idle_det);
        if (rx.valid)    obs_valid_data = rx.data_out;
        if (rx.idle_det) obs_idle_data  = rx.data_out;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx.serial_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_32f);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            rx.serial_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            n_checks++;
            if (obs_vec() !== 14'h0)
                $display("FAIL reset_hold cyc %0d: got %h want %h", c, obs_vec(), 14'h0);
            else n_pass++;
        end
        rst = 1'b0;
        q_bits = {};
        add_byte(8'h5A);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL reset_after bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        do_reset();
        clr_obs();
        q_bits = {};
        repeat (4) add_byte(8'hBC);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL lock bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 7) begin
                n_checks++;
                if (rx.state !== 2'd1 || rx.com_det !== 1'b0)
                    $display("FAIL lock_align_entry: state %0d com %b want 1 0", rx.state, rx.com_det);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_com !== 3) $display("FAIL lock_com_count: got %0d want 3", obs_com);
        else n_pass++;
        n_checks++;
        if (rx.active !== 1'b1 || rx.state !== 2'd2)
            $display("FAIL lock_active: active %b state %0d want 1 2", rx.active, rx.state);
        else n_pass++;
    endtask

    task automatic test_shifted();
        do_reset();
        clr_obs();
        q_bits = {};
        repeat (3) q_bits.push_back(1'($urandom_range(0, 1)));
        repeat (4) add_byte(8'hBC);
        add_byte(8'h7C);
        add_byte(8'hA5);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL shifted bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (obs_idle !== 1 || obs_idle_data !== 8'h7C)
            $display("FAIL shifted_idle: count %0d data %h want 1 7c", obs_idle, obs_idle_data);
        else n_pass++;
        n_checks++;
        if (obs_valid !== 1 || obs_valid_data !== 8'hA5)
            $display("FAIL shifted_valid: count %0d data %h want 1 a5", obs_valid, obs_valid_data);
        else n_pass++;
    endtask

    task automatic test_align_fail();
        do_reset();
        clr_obs();
        q_bits = {};
        add_byte(8'hBC);
        add_byte(8'hBC);
        add_byte(8'h7C);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL align_fail bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (rx.state !== 2'd0 || rx.active !== 1'b0 || obs_idle !== 0 || obs_com !== 1)
            $display("FAIL align_fail_end: state %0d active %b idle %0d com %0d want 0 0 0 1",
                     rx.state, rx.active, obs_idle, obs_com);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        q_bits = {};
        repeat (4) add_byte(8'hBC);
        foreach (q_bits[i]) drive_bit(q_bits[i]);
        clr_obs();
        q_bits = {};
        repeat (16) add_byte(8'h7C);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL timeout bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 126) begin
                n_checks++;
                if (rx.active !== 1'b1) $display("FAIL timeout_pre: active %b want 1", rx.active);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_idle !== 15) $display("FAIL timeout_idle_count: got %0d want 15", obs_idle);
        else n_pass++;
        n_checks++;
        if (rx.active !== 1'b0 || rx.state !== 2'd0 || rx.idle_det !== 1'b0)
            $display("FAIL timeout_drop: active %b state %0d idle %b want 0 0 0",
                     rx.active, rx.state, rx.idle_det);
        else n_pass++;
    endtask

    task automatic test_gap_reset();
        int n_inact;
        do_reset();
        q_bits = {};
        repeat (4) add_byte(8'hBC);
        foreach (q_bits[i]) drive_bit(q_bits[i]);
        clr_obs();
        n_inact = 0;
        q_bits = {};
        repeat (15) add_byte(8'h7C);
        add_byte(8'hBC);
        repeat (15) add_byte(8'h7C);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            if (rx.active !== 1'b1) n_inact++;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL gap_reset bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (n_inact !== 0 || obs_idle !== 30 || obs_com !== 1)
            $display("FAIL gap_reset_end: inactive %0d idle %0d com %0d want 0 30 1",
                     n_inact, obs_idle, obs_com);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        q_bits = {};
        repeat (4) add_byte(8'hBC);
        foreach (q_bits[i]) drive_bit(q_bits[i]);
        q_bits = {1'b1, 1'b0, 1'b1, 1'b0};
        foreach (q_bits[i]) drive_bit(q_bits[i]);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 14'h0)
            $display("FAIL reset_mid_async: got %h want %h", obs_vec(), 14'h0);
        else n_pass++;
        @(posedge clk_32f);
        #1;
        rst = 1'b0;
        clr_obs();
        q_bits = {};
        repeat (3) add_byte(8'hBC);
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL reset_mid bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (rx.active !== 1'b0 || rx.state !== 2'd1)
            $display("FAIL reset_mid_3com: active %b state %0d want 0 1", rx.active, rx.state);
        else n_pass++;
        q_bits = {};
        add_byte(8'hBC);
        foreach (q_bits[i]) drive_bit(q_bits[i]);
        n_checks++;
        if (rx.active !== 1'b1) $display("FAIL reset_mid_relock: active %b want 1", rx.active);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        clr_obs();
        q_bits = {};
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35)      add_byte(8'hBC);
            else if (r < 60) add_byte(8'h7C);
            else if (r < 90) add_byte(8'($urandom));
            else if (r < 95) repeat (int'($urandom_range(1, 7))) q_bits.push_back(1'($urandom_range(0, 1)));
            else repeat (17) add_byte(8'h7C);
        end
        foreach (q_bits[i]) begin
            drive_bit(q_bits[i]);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random bit %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx.serial_in = 1'b0;
        model_reset();
        clr_obs();
        #1;
        test_reset();
        test_lock();
        test_shifted();
        test_align_fail();
        test_timeout();
        test_gap_reset();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/phy_rx_sync_ctrl.md
PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 Parameter COM_LOCK, default 4, consecutive byte-aligned COM (8'hBC) symbols required to declare lock; legal range 2..15.
REQ-002 Parameter COM_TIMEOUT, default 16, consecutive non-COM bytes in SYNC that cause loss of lock; legal range 2..255.
REQ-003 clk_32f  input  1  bit clock; every signal is sampled on its rising edge; one serial bit per cycle.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 serial_in  input  1  received serial bit stream, MSB of each byte first.
REQ-006 active  output  1  high while the link is locked (SYNC state); drives the serializer's active select.
REQ-007 data_out  output  8  last completed byte, registered.
REQ-008 valid  output  1  one-cycle pulse; data_out holds a data byte (neither 8'hBC nor 8'h7C).
REQ-009 com_det  output  1  one-cycle pulse; data_out holds a COM byte (8'hBC) received in ALIGN or SYNC.
REQ-010 idle_det  output  1  one-cycle pulse; data_out holds an IDLE byte (8'h7C) received in SYNC.
REQ-011 state  output  2  current state: 2'd0 UNSYNC, 2'd1 ALIGN, 2'd2 SYNC.

Function
REQ-012 Shift register sr[7:0] updates every cycle as sr <= {sr[6:0], serial_in}; sr_next is that updated value and is what all byte comparisons use.
REQ-013 UNSYNC: bit counter is held at 0. When sr_next == 8'hBC, go to ALIGN with bit_cnt <= 0 and com_cnt <= 1. Any other value keeps the state at UNSYNC.
REQ-014 ALIGN and SYNC: bit_cnt increments by 1 every cycle, modulo 8. A byte boundary is a cycle with bit_cnt == 7. The first boundary falls exactly 8 cycles after the alignment match.
REQ-015 ALIGN, at a boundary, sr_next == 8'hBC: com_cnt increments. If the new count equals COM_LOCK, go to SYNC and clear gap_cnt.
REQ-016 ALIGN, at a boundary, sr_next != 8'hBC: go to UNSYNC and clear com_cnt. The comma search restarts on the next cycle; the failing byte is not re-searched.
REQ-017 SYNC, at a boundary, sr_next == 8'hBC: clear gap_cnt.
REQ-018 SYNC, at a boundary, any other byte: increment gap_cnt. If the incremented value equals COM_TIMEOUT, go to UNSYNC and emit no pulse for that byte.
REQ-019 active is a registered output equal to (state == SYNC). It rises the cycle after the locking boundary and falls the cycle after the timeout boundary.
REQ-020 Boundary outputs, one cycle after the boundary: data_out <= sr_next, plus exactly one of these pulses for one cycle:
  - valid for a data byte in SYNC
  - idle_det for 8'h7C in SYNC
  - com_det for 8'hBC in ALIGN or SYNC
REQ-021 No pulses in UNSYNC. data_out holds its last value between boundaries and through state changes.
REQ-022 com_cnt and gap_cnt saturate and never wrap. State encoding 2'd3 is unreachable; if entered, the next cycle is UNSYNC.
REQ-023 The transition into ALIGN and the COM pulse of the first ALIGN boundary never coincide. The alignment match itself produces no com_det.

Reset
REQ-024 While rst = 1, regardless of clock:
  - state = UNSYNC
  - sr, bit_cnt, com_cnt, gap_cnt = 0
  - active, valid, com_det, idle_det = 0
  - data_out = 8'h00
REQ-025 Reset asserted mid-byte or mid-lock aborts at once. After deassertion the block searches from UNSYNC with an empty shift register; a partial byte is never emitted.

Verification
REQ-026 After reset, send 8'hBC x4 MSB-first from bit 0 -> state goes UNSYNC->ALIGN after the 8th bit, com_det pulses 3 times, active = 1 one cycle after bit 32.
REQ-027 3 garbage bits, then 8'hBC x4, then 8'h7C, 8'hA5 -> lock is achieved on the shifted alignment, idle_det pulses once with data_out = 8'h7C, then valid pulses once with data_out = 8'hA5.
REQ-028 8'hBC x2, then 8'h7C while in ALIGN -> state returns to UNSYNC, active stays 0, no idle_det pulse.
REQ-029 Locked, then 16 bytes of 8'h7C with COM_TIMEOUT = 16 -> 15 idle_det pulses, no pulse for the 16th byte, active falls one cycle after its boundary, state = UNSYNC.
REQ-030 Locked, then 15 x 8'h7C, 8'hBC, 15 x 8'h7C -> active stays 1 throughout.
REQ-031 rst pulsed at bit 4 of a data byte in SYNC -> all outputs are 0 immediately, and re-lock needs a fresh 4 x 8'hBC.
